// File: rtl/universal_shift_reg.sv
// Universal shift register with load/shift/rotate/clear modes and a burst engine
// that repeats a shift or rotate op shamt times, flagging busy and a done pulse.
module universal_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                SW        = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic [SW-1:0]    shamt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_LOAD  = 3'b001,
        OP_SHL   = 3'b010,
        OP_SHR   = 3'b011,
        OP_ROL   = 3'b100,
        OP_ROR   = 3'b101,
        OP_ASR   = 3'b110,
        OP_CLEAR = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [SW-1:0]    count_q, count_d;
    op_e              op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic [WIDTH-1:0] step_fn(
        input op_e              o,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] ld,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        case (o)
            OP_LOAD:  r = ld;
            OP_SHL:   r = {v[WIDTH-2:0], sr};
            OP_SHR:   r = {sl, v[WIDTH-1:1]};
            OP_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:   r = {v[0], v[WIDTH-1:1]};
            OP_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_CLEAR: r = '0;
            default:  r = v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            q_q     <= RESET_VAL;
            count_q <= '0;
            op_q    <= OP_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            count_q <= count_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        count_d = count_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    if (!start) begin
                        q_d = step_fn(op_e'(op), q_q, d, sin_l, sin_r);
                    end else if (shamt == '0) begin
                        done_d = 1'b1;
                    end else if (op_e'(op) == OP_HOLD || op_e'(op) == OP_LOAD ||
                                 op_e'(op) == OP_CLEAR) begin
                        q_d    = step_fn(op_e'(op), q_q, d, sin_l, sin_r);
                        done_d = 1'b1;
                    end else begin
                        // First step happens on the accept edge, so RUN covers shamt-1 steps.
                        op_d    = op_e'(op);
                        q_d     = step_fn(op_e'(op), q_q, d, sin_l, sin_r);
                        count_d = shamt - SW'(1);
                        if (shamt == SW'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            busy_d  = 1'b1;
                            state_d = S_RUN;
                        end
                    end
                end
            end
            S_RUN: begin
                if (en) begin
                    q_d     = step_fn(op_q, q_q, d, sin_l, sin_r);
                    count_d = count_q - SW'(1);
                    if (count_q == SW'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: directed vector table, hand-written burst sequences,
// and randomized cycles compared against an integer reference model.
module tb_universal_shift_reg;

    localparam int W    = 8;
    localparam int SW   = $clog2(W) + 1;
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset, en, start, sin_l, sin_r;
    logic [2:0]    op;
    logic [SW-1:0] shamt;
    logic [W-1:0]  d;
    logic [W-1:0]  q;
    logic          sout_l, sout_r, busy, done;

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    int mq = 0, mrem = 0, mbusy = 0, mdone = 0, mlop = 0;

    universal_shift_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .start(start), .shamt(shamt),
        .d(d), .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l), .sout_r(sout_r),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int apply(int o, int v, int dd, int sl, int sr);
        case (o)
            1: return dd & MASK;
            2: return ((v << 1) & MASK) | sr;
            3: return (v >> 1) | (sl << (W - 1));
            4: return ((v << 1) & MASK) | (v >> (W - 1));
            5: return (v >> 1) | ((v & 1) << (W - 1));
            6: return (v >> 1) | (v & (1 << (W - 1)));
            7: return 0;
            default: return v;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle of inputs, advance the reference model, clock, then settle.
    task automatic cyc(input int r, input int e, input int o, input int s,
                       input int sh, input int dd, input int sl, input int sr);
        reset = r[0]; en = e[0]; op = o[2:0]; start = s[0];
        shamt = sh[SW-1:0]; d = dd[W-1:0]; sin_l = sl[0]; sin_r = sr[0];
        mdone = 0;
        if (r != 0) begin
            mq = 0; mrem = 0; mbusy = 0;
        end else if (mrem > 0) begin
            if (e != 0) begin
                mq = apply(mlop, mq, dd, sl, sr);
                mrem--;
                if (mrem == 0) begin mbusy = 0; mdone = 1; end
            end
        end else if (e != 0) begin
            if (s == 0) mq = apply(o, mq, dd, sl, sr);
            else if (sh == 0) mdone = 1;
            else if (o == 0 || o == 1 || o == 7) begin
                mq = apply(o, mq, dd, sl, sr); mdone = 1;
            end else begin
                mlop = o;
                mq = apply(o, mq, dd, sl, sr);
                mrem = sh - 1;
                if (mrem == 0) mdone = 1; else mbusy = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string name, input int eq, input int eb, input int ed);
        chk({name, ".q"}, int'(q), eq);
        chk({name, ".busy"}, int'(busy), eb);
        chk({name, ".done"}, int'(done), ed);
    endtask

    typedef struct {
        int r, e, o, s, sh, dd, sl, sr;
        int eq, eb, ed;
    } vec_t;

    vec_t tbl[9];

    initial begin
        reset = 1'b1; en = 1'b0; op = 3'd0; start = 1'b0;
        shamt = '0; d = '0; sin_l = 1'b0; sin_r = 1'b0;

        //          r  e  op st sh  d    sl sr   q    b  d
        tbl[0] = '{1, 1, 1, 0, 0, 'hA5, 0, 0, 'h00, 0, 0};
        tbl[1] = '{1, 1, 1, 0, 0, 'hA5, 0, 0, 'h00, 0, 0};
        tbl[2] = '{0, 1, 1, 0, 0, 'hA5, 0, 0, 'hA5, 0, 0};
        tbl[3] = '{0, 1, 4, 0, 0, 'h00, 0, 0, 'h4B, 0, 0};
        tbl[4] = '{0, 1, 3, 0, 0, 'h00, 1, 0, 'hA5, 0, 0};
        tbl[5] = '{0, 1, 5, 1, 3, 'h00, 0, 0, 'hD2, 1, 0};
        tbl[6] = '{0, 1, 1, 1, 2, 'h00, 0, 0, 'h69, 1, 0};
        tbl[7] = '{0, 1, 0, 0, 0, 'h00, 0, 0, 'hB4, 0, 1};
        tbl[8] = '{0, 1, 0, 0, 0, 'h00, 0, 0, 'hB4, 0, 0};

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].r, tbl[i].e, tbl[i].o, tbl[i].s, tbl[i].sh,
                tbl[i].dd, tbl[i].sl, tbl[i].sr);
            chk3($sformatf("vec%0d", i), tbl[i].eq, tbl[i].eb, tbl[i].ed);
        end
        chk("vec.sout_l", int'(sout_l), 1);
        chk("vec.sout_r", int'(sout_r), 0);

        // ASR burst of 4 with a 2-cycle stall
        cyc(0, 1, 1, 0, 0, 'h90, 0, 0);
        cyc(0, 1, 6, 1, 4, 0, 0, 0); chk3("asr.e0", 'hC8, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0); chk3("asr.st0", 'hC8, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0); chk3("asr.st1", 'hC8, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0); chk3("asr.e1", 'hE4, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0); chk3("asr.e2", 'hF2, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0); chk3("asr.e3", 'hF9, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0); chk3("asr.after", 'hF9, 0, 0);

        // SHL burst of 8 from zero, start held high throughout the burst
        cyc(0, 1, 7, 0, 0, 0, 0, 0); chk3("shl.clr", 'h00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 2, 1, 8, 0, 0, 1);
            chk3($sformatf("shl.e%0d", i), (1 << (i + 1)) - 1, (i < 7) ? 1 : 0, (i == 7) ? 1 : 0);
        end
        cyc(0, 1, 0, 0, 0, 0, 0, 0); chk3("shl.after", 'hFF, 0, 0);

        // reset mid-burst, then a zero-length burst
        cyc(0, 1, 1, 0, 0, 'h81, 0, 0);
        cyc(0, 1, 2, 1, 5, 0, 0, 0); chk3("abort.e0", 'h02, 1, 0);
        cyc(1, 1, 2, 1, 5, 0, 0, 0); chk3("abort.rst", 'h00, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0); chk3("abort.after", 'h00, 0, 0);
        cyc(0, 1, 1, 0, 0, 'h3C, 0, 0);
        cyc(0, 1, 2, 1, 0, 0, 0, 1); chk3("zero.e0", 'h3C, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0); chk3("zero.after", 'h3C, 0, 0);

        // randomized cycles against the reference model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(63) == 0) ? 1 : 0,
                ($urandom_range(3) != 0) ? 1 : 0,
                int'($urandom_range(7)),
                ($urandom_range(3) == 0) ? 1 : 0,
                int'($urandom_range((1 << SW) - 1)),
                int'($urandom_range(MASK)),
                int'($urandom_range(1)),
                int'($urandom_range(1)));
            chk3($sformatf("rnd%0d", i), mq, mbusy, mdone);
            chk($sformatf("rnd%0d.sout_l", i), int'(sout_l), (mq >> (W - 1)) & 1);
            chk($sformatf("rnd%0d.sout_r", i), int'(sout_r), mq & 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
